// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter among NREQ byte sources. Free requesters are
// picked round-robin. A requester that sends a byte without its last flag
// keeps the transmitter (frame lock) until it sends a byte flagged last. The
// block sequences the UART send_data / TiP handshake. It raises err if TiP
// never rises after a send.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   req        per-requester byte valid, held until the matching ack
//   last       per-requester end-of-frame flag, qualified with req
//   data       flattened bytes, requester i drives data[8*i+7:8*i]
//   ack        one-cycle pulse: the requester's byte has been latched
//   grant      one-hot owner of the transmitter, all zero when free
//   busy       high whenever the FSM is not IDLE
//   err        one-cycle pulse when the UART fails to start
//   uart_data  byte to the UART I_DATA input, stable between latches
//   uart_send  one-cycle send_data strobe to the UART
//   uart_tip   UART transmission-in-progress flag
// ----------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int NREQ          = 4,
   parameter int START_TIMEOUT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   last,
   input  logic [8*NREQ-1:0] data,
   output logic [NREQ-1:0]   ack,
   output logic [NREQ-1:0]   grant,
   output logic              busy,
   output logic              err,
   output logic [7:0]        uart_data,
   output logic              uart_send,
   input  logic              uart_tip
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

   typedef enum logic [2:0] {
      IDLE,
      SEND,
      WAIT_BUSY,
      WAIT_DONE,
      HOLD
   } state_e;

   state_e             state_q;
   logic               lock_q;
   logic [IDX_W-1:0]   ptr_q;
   logic [IDX_W-1:0]   gidx_q;
   logic [NREQ-1:0]    grant_q;
   logic [NREQ-1:0]    ack_q;
   logic               err_q;
   logic [7:0]         data_q;
   logic               send_q;
   logic [CNT_W-1:0]   cnt_q;

   logic               win_vld;
   logic [IDX_W-1:0]   win_idx;
   logic [IDX_W-1:0]   cand;

   function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [NREQ-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

   // Round-robin search starting just after the last served index. The loop
   // runs from the farthest candidate to the nearest so that the nearest
   // requesting index is the one left in win_idx.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      cand    = '0;
      for (int k = NREQ; k >= 1; k--) begin
         cand = IDX_W'((int'(ptr_q) + k) % NREQ);
         if (req[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         lock_q  <= 1'b0;
         ptr_q   <= IDX_W'(NREQ - 1);
         gidx_q  <= '0;
         grant_q <= '0;
         ack_q   <= '0;
         err_q   <= 1'b0;
         data_q  <= '0;
         send_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         ack_q  <= '0;
         err_q  <= 1'b0;
         send_q <= 1'b0;
         case (state_q)
            // A UART still busy (e.g. after a reset mid-byte) blocks arbitration.
            IDLE: begin
               if (!uart_tip && win_vld) begin
                  gidx_q  <= win_idx;
                  grant_q <= onehot(win_idx);
                  ack_q   <= onehot(win_idx);
                  data_q  <= data[win_idx*8 +: 8];
                  lock_q  <= ~last[win_idx];
                  state_q <= SEND;
               end
            end
            SEND: begin
               send_q  <= 1'b1;
               cnt_q   <= '0;
               state_q <= WAIT_BUSY;
            end
            // The UART registers send_data, so TiP shows up a couple of
            // cycles later. Give up after START_TIMEOUT cycles.
            WAIT_BUSY: begin
               if (uart_tip) begin
                  state_q <= WAIT_DONE;
               end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
                  err_q   <= 1'b1;
                  lock_q  <= 1'b0;
                  grant_q <= '0;
                  ptr_q   <= gidx_q;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (!uart_tip) begin
                  if (lock_q) begin
                     state_q <= HOLD;
                  end else begin
                     grant_q <= '0;
                     ptr_q   <= gidx_q;
                     state_q <= IDLE;
                  end
               end
            end
            // Frame locked: only the owner is looked at, however long it idles.
            HOLD: begin
               if (req[gidx_q] && !uart_tip) begin
                  ack_q   <= grant_q;
                  data_q  <= data[gidx_q*8 +: 8];
                  lock_q  <= ~last[gidx_q];
                  state_q <= SEND;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ack       = ack_q;
   assign grant     = grant_q;
   assign busy      = (state_q != IDLE);
   assign err       = err_q;
   assign uart_data = data_q;
   assign uart_send = send_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
   localparam int NREQ    = 4;
   localparam int ST      = 8;
   localparam int TIP_LEN = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req, last;
   logic [31:0] data;
   logic [3:0]  ack, grant;
   logic        busy, err, uart_send;
   logic [7:0]  uart_data;
   logic        uart_tip;

   logic        mdl_en  = 1'b0;
   logic        man_tip = 1'b0;
   logic        mdl_tip = 1'b0;
   logic [1:0]  mdl_st  = 2'd0;
   int          mdl_len = 0;
   logic        mon_en  = 1'b0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NREQ(NREQ), .START_TIMEOUT(ST)) dut (
      .clk(clk), .rst(rst), .req(req), .last(last), .data(data),
      .ack(ack), .grant(grant), .busy(busy), .err(err),
      .uart_data(uart_data), .uart_send(uart_send), .uart_tip(uart_tip)
   );

   // UART model: TiP rises two cycles after send_data and stays high TIP_LEN cycles.
   always @(posedge clk) begin
      if (!mdl_en) begin
         mdl_tip <= 1'b0;
         mdl_st  <= 2'd0;
      end else if (mdl_st == 2'd0) begin
         if (uart_send) mdl_st <= 2'd1;
      end else if (mdl_st == 2'd1) begin
         mdl_tip <= 1'b1;
         mdl_len <= TIP_LEN - 1;
         mdl_st  <= 2'd2;
      end else begin
         if (mdl_len == 0) begin
            mdl_tip <= 1'b0;
            mdl_st  <= 2'd0;
         end else begin
            mdl_len <= mdl_len - 1;
         end
      end
   end

   assign uart_tip = mdl_en ? mdl_tip : man_tip;

   // Structural invariants checked every cycle.
   always @(negedge clk) begin
      if (mon_en) begin
         total++;
         if (!$onehot0(ack) || !$onehot0(grant)) begin
            bad++;
            $display("FAIL onehot0 ack=%b grant=%b required one-hot or zero", ack, grant);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; last = '0; data = '0; man_tip = 1'b0; mdl_en = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic wait_ack(output bit ok);
      int n = 0;
      while (ack == 4'b0 && n < 80) begin step(); n++; end
      ok = (ack != 4'b0);
   endtask

   task automatic wait_send(output bit ok);
      int n = 0;
      while (!uart_send && n < 8) begin step(); n++; end
      ok = uart_send;
   endtask

   task automatic wait_idle(output bit ok);
      int n = 0;
      while (busy && n < 80) begin step(); n++; end
      ok = !busy;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 4'b1111; last = 4'b1111; data = 32'hDEADBEEF;
      man_tip = 1'b0; mdl_en = 1'b0;
      step(); step(); step();
      mon_en = 1'b1;
      total++; if (ack !== 4'b0)   begin bad++; $display("FAIL rst_ack got=%b want=0000", ack); end
      total++; if (grant !== 4'b0) begin bad++; $display("FAIL rst_grant got=%b want=0000", grant); end
      total++; if (busy !== 1'b0)  begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
      total++; if (err !== 1'b0)   begin bad++; $display("FAIL rst_err got=%b want=0", err); end
      total++; if (uart_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h want=00", uart_data); end
      total++; if (uart_send !== 1'b0)  begin bad++; $display("FAIL rst_send got=%b want=0", uart_send); end
      rst = 1'b0; req = '0;
   endtask

   task automatic test_single_byte();
      bit ok;
      do_reset();
      mdl_en = 1'b1;
      req = 4'b0001; last = 4'b0001; data = 32'h000000A5;
      step();
      total++; if (ack !== 4'b0001)   begin bad++; $display("FAIL sb_ack got=%b want=0001", ack); end
      total++; if (grant !== 4'b0001) begin bad++; $display("FAIL sb_grant got=%b want=0001", grant); end
      total++; if (uart_send !== 1'b0) begin bad++; $display("FAIL sb_send_early got=%b want=0", uart_send); end
      req = '0;
      step();
      total++; if (uart_send !== 1'b1) begin bad++; $display("FAIL sb_send got=%b want=1", uart_send); end
      total++; if (uart_data !== 8'hA5) begin bad++; $display("FAIL sb_data got=%h want=a5", uart_data); end
      total++; if (ack !== 4'b0) begin bad++; $display("FAIL sb_ack_pulse got=%b want=0000", ack); end
      step();
      total++; if (uart_send !== 1'b0) begin bad++; $display("FAIL sb_send_pulse got=%b want=0", uart_send); end
      wait_idle(ok);
      total++; if (!ok) begin bad++; $display("FAIL sb_idle busy=%b want=0", busy); end
      total++; if (grant !== 4'b0) begin bad++; $display("FAIL sb_grant_free got=%b want=0000", grant); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL sb_err got=%b want=0", err); end
   endtask

   task automatic test_round_robin();
      int order[5] = '{0, 1, 2, 3, 0};
      logic [3:0] expv;
      logic [7:0] expb;
      int w, sends;
      bit ok;
      do_reset();
      mdl_en = 1'b1;
      data = 32'h44332211; last = 4'b1111; req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         expv = 4'(1 << order[n]);
         expb = 8'(8'h11 * (order[n] + 1));
         w = 0; sends = 0;
         while (ack == 4'b0 && w < 80) begin
            step(); w++;
            if (uart_send) sends++;
         end
         total++;
         if (ack !== expv) begin bad++; $display("FAIL rr_ack[%0d] got=%b want=%b", n, ack, expv); end
         total++;
         if (grant !== expv) begin bad++; $display("FAIL rr_grant[%0d] got=%b want=%b", n, grant, expv); end
         total++;
         if (sends != 0) begin bad++; $display("FAIL rr_extra_send[%0d] got=%0d want=0", n, sends); end
         wait_send(ok);
         total++;
         if (!ok || uart_data !== expb) begin
            bad++; $display("FAIL rr_data[%0d] send=%b got=%h want=%h", n, uart_send, uart_data, expb);
         end
      end
      req = '0;
      wait_idle(ok);
      total++; if (!ok) begin bad++; $display("FAIL rr_idle busy=%b want=0", busy); end
   endtask

   task automatic test_frame_lock();
      bit ok;
      do_reset();
      mdl_en = 1'b1;
      req = 4'b0100; last = 4'b0000; data = 32'h00110000;
      wait_ack(ok);
      total++; if (ack !== 4'b0100 || grant !== 4'b0100) begin bad++; $display("FAIL fl_b1 ack=%b grant=%b want=0100", ack, grant); end
      data[23:16] = 8'h22; req[1] = 1'b1; data[15:8] = 8'h77; last[1] = 1'b1;
      wait_send(ok);
      total++; if (!ok || uart_data !== 8'h11) begin bad++; $display("FAIL fl_d1 got=%h want=11", uart_data); end
      wait_ack(ok);
      total++; if (ack !== 4'b0100 || grant !== 4'b0100) begin bad++; $display("FAIL fl_b2 ack=%b grant=%b want=0100", ack, grant); end
      data[23:16] = 8'h33; last[2] = 1'b1;
      wait_send(ok);
      total++; if (!ok || uart_data !== 8'h22) begin bad++; $display("FAIL fl_d2 got=%h want=22", uart_data); end
      wait_ack(ok);
      total++; if (ack !== 4'b0100 || grant !== 4'b0100) begin bad++; $display("FAIL fl_b3 ack=%b grant=%b want=0100", ack, grant); end
      req[2] = 1'b0;
      wait_send(ok);
      total++; if (!ok || uart_data !== 8'h33) begin bad++; $display("FAIL fl_d3 got=%h want=33", uart_data); end
      wait_ack(ok);
      total++; if (ack !== 4'b0010 || grant !== 4'b0010) begin bad++; $display("FAIL fl_next ack=%b grant=%b want=0010", ack, grant); end
      req[1] = 1'b0;
      wait_send(ok);
      total++; if (!ok || uart_data !== 8'h77) begin bad++; $display("FAIL fl_d4 got=%h want=77", uart_data); end
      wait_idle(ok);
      total++; if (!ok) begin bad++; $display("FAIL fl_idle busy=%b want=0", busy); end
   endtask

   task automatic test_start_timeout();
      int first_err = 0;
      int pulses = 0;
      logic [3:0] g_at = 4'bxxxx;
      logic       b_at = 1'bx;
      do_reset();
      mdl_en = 1'b0; man_tip = 1'b0;
      req = 4'b0001; last = 4'b0000; data = 32'h0000BB5C;
      step();
      total++; if (ack !== 4'b0001) begin bad++; $display("FAIL to_ack got=%b want=0001", ack); end
      req = '0;
      // uart_send (and WAIT_BUSY entry) is one cycle after ack, err ST cycles later.
      for (int k = 1; k <= ST + 3; k++) begin
         step();
         if (err) begin
            pulses++;
            if (first_err == 0) begin first_err = k; g_at = grant; b_at = busy; end
         end
      end
      total++; if (first_err != ST + 1) begin bad++; $display("FAIL to_err_time got=%0d want=%0d", first_err, ST + 1); end
      total++; if (pulses != 1) begin bad++; $display("FAIL to_err_pulses got=%0d want=1", pulses); end
      total++; if (g_at !== 4'b0 || b_at !== 1'b0) begin bad++; $display("FAIL to_release grant=%b busy=%b want=0000/0", g_at, b_at); end
      mdl_en = 1'b1;
      req = 4'b0011; last = 4'b0011;
      step();
      total++; if (ack !== 4'b0010) begin bad++; $display("FAIL to_next_ack got=%b want=0010", ack); end
      req = '0;
      step();
      total++; if (uart_send !== 1'b1 || uart_data !== 8'hBB) begin bad++; $display("FAIL to_next_send send=%b data=%h want=1/bb", uart_send, uart_data); end
   endtask

   task automatic test_reset_mid_tx();
      int stray = 0;
      do_reset();
      mdl_en = 1'b0; man_tip = 1'b0;
      req = 4'b1000; last = 4'b1000; data = 32'hC3000000;
      step();
      total++; if (ack !== 4'b1000) begin bad++; $display("FAIL rm_ack got=%b want=1000", ack); end
      data[31:24] = 8'h3C;
      step();
      total++; if (uart_send !== 1'b1) begin bad++; $display("FAIL rm_send got=%b want=1", uart_send); end
      man_tip = 1'b1;
      step();
      step();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL rm_busy got=%b want=1", busy); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      total++;
      if (ack !== 4'b0 || grant !== 4'b0 || busy !== 1'b0 || err !== 1'b0 || uart_data !== 8'h00 || uart_send !== 1'b0) begin
         bad++;
         $display("FAIL rm_outputs ack=%b grant=%b busy=%b err=%b data=%h send=%b want all zero",
                  ack, grant, busy, err, uart_data, uart_send);
      end
      for (int k = 0; k < 4; k++) begin
         step();
         if (ack !== 4'b0 || uart_send !== 1'b0) stray++;
      end
      total++; if (stray != 0) begin bad++; $display("FAIL rm_blocked got=%0d stray cycles want=0", stray); end
      man_tip = 1'b0;
      step();
      total++; if (ack !== 4'b1000 || uart_data !== 8'h3C) begin bad++; $display("FAIL rm_resume ack=%b data=%h want=1000/3c", ack, uart_data); end
      req = '0;
   endtask

   task automatic test_busy_gate();
      int early = 0;
      int n = 0;
      do_reset();
      mdl_en = 1'b1;
      req = 4'b0001; last = 4'b0011; data = 32'h00000A5A;
      step();
      total++; if (ack !== 4'b0001) begin bad++; $display("FAIL bg_ack0 got=%b want=0001", ack); end
      req = '0;
      while (n < 80) begin
         step(); n++;
         if (!busy) break;
         if (ack !== 4'b0) early++;
         req[1] = ~req[1];
      end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL bg_idle busy=%b want=0", busy); end
      total++; if (early != 0 || ack !== 4'b0) begin bad++; $display("FAIL bg_early got=%0d acks want=0", early); end
      req = 4'b0010;
      step();
      total++; if (ack !== 4'b0010 || grant !== 4'b0010) begin bad++; $display("FAIL bg_ack1 ack=%b grant=%b want=0010", ack, grant); end
      req = '0;
      step();
      total++; if (uart_send !== 1'b1 || uart_data !== 8'h0A) begin bad++; $display("FAIL bg_send send=%b data=%h want=1/0a", uart_send, uart_data); end
   endtask

   initial begin
      rst = 1'b1; req = '0; last = '0; data = '0;
      test_reset();
      test_single_byte();
      test_round_robin();
      test_frame_lock();
      test_start_timeout();
      test_reset_mid_tx();
      test_busy_gate();
      do_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
